// File: rtl/float_muldiv_seq.sv
// Multi-cycle floating-point multiplier/divider over {s, exp[Ne-1:0], mant[Nm-1:0]}.
// Shift-add multiply, restoring divide, truncating rounding, start/done handshake.
module float_muldiv_seq #(
    parameter int Nm = 23,
    parameter int Ne = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                op_i,
    input  logic [Ne+Nm:0]      op_a_i,
    input  logic [Ne+Nm:0]      op_b_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [Ne+Nm:0]      res_o,
    output logic [3:0]          flags_o
);
    localparam int W    = 1 + Ne + Nm;
    localparam int PW   = 2 * Nm + 2;
    localparam int EW   = Ne + 2;
    localparam int CW   = $clog2(Nm + 3);
    localparam int BIAS = 2 ** (Ne - 1) - 1;
    localparam int EMAX = 2 ** Ne - 1;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ITER,
        NORM,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [Nm:0]     mplier_q, mplier_d;
    logic [Nm+2:0]   rem_q, rem_d;
    logic [Nm+1:0]   quo_q, quo_d;
    logic [W-1:0]    pres_q, pres_d, res_q, res_d;
    logic [3:0]      pflags_q, pflags_d, flags_q, flags_d;
    logic            done_q, done_d, ready_q, ready_d;

    logic            sa, sb, s_res;
    logic [Ne-1:0]   ea, eb;
    logic [Nm:0]     ma, mb;
    logic            a_zero, a_inf, b_zero, b_inf;
    logic [W-1:0]    inf_val, nan_val, zero_val;
    logic [Nm-1:0]   mant_n;
    logic [EW-1:0]   exp_n;

    assign sa       = a_q[W-1];
    assign sb       = b_q[W-1];
    assign ea       = a_q[W-2:Nm];
    assign eb       = b_q[W-2:Nm];
    assign ma       = {1'b1, a_q[Nm-1:0]};
    assign mb       = {1'b1, b_q[Nm-1:0]};
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == '1);
    assign b_inf    = (eb == '1);
    assign s_res    = sa ^ sb;
    assign inf_val  = {s_res, {Ne{1'b1}}, {Nm{1'b0}}};
    assign nan_val  = {s_res, {Ne{1'b1}}, {Nm{1'b1}}};
    assign zero_val = {s_res, {(W-1){1'b0}}};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        pres_d   = pres_q;
        pflags_d = pflags_q;
        res_d    = res_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mant_n   = '0;
        exp_n    = '0;

        case (state_q)
            IDLE: begin
                if (start_i && ready_q) begin
                    state_d = UNPACK;
                    op_d    = op_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                end
            end

            UNPACK: begin
                sign_d   = s_res;
                pflags_d = 4'b0000;
                state_d  = DONE;
                if (!op_q) begin
                    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                        pres_d   = nan_val;
                        pflags_d = 4'b1000;
                    end else if (a_inf || b_inf) begin
                        pres_d = inf_val;
                    end else if (a_zero || b_zero) begin
                        pres_d = zero_val;
                    end else begin
                        state_d = ITER;
                    end
                end else begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        pres_d   = nan_val;
                        pflags_d = 4'b1000;
                    end else if (a_inf) begin
                        pres_d = inf_val;
                    end else if (b_zero) begin
                        pres_d   = inf_val;
                        pflags_d = 4'b0100;
                    end else if (a_zero || b_inf) begin
                        pres_d = zero_val;
                    end else begin
                        state_d = ITER;
                    end
                end
                // Iteration count is loaded as N-1 so ITER lasts exactly N cycles.
                cnt_d    = op_q ? CW'(Nm + 1) : CW'(Nm);
                acc_d    = '0;
                mcand_d  = PW'(ma);
                mplier_d = mb;
                rem_d    = {2'b00, ma};
                quo_d    = '0;
                if (op_q)
                    exp_d = EW'(ea) - EW'(eb) + EW'(BIAS);
                else
                    exp_d = EW'(ea) + EW'(eb) - EW'(BIAS);
            end

            ITER: begin
                if (!op_q) begin
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    if (rem_q >= {2'b00, mb}) begin
                        quo_d = {quo_q[Nm:0], 1'b1};
                        rem_d = (rem_q - {2'b00, mb}) << 1;
                    end else begin
                        quo_d = {quo_q[Nm:0], 1'b0};
                        rem_d = rem_q << 1;
                    end
                end
                if (cnt_q == '0)
                    state_d = NORM;
                else
                    cnt_d = cnt_q - 1'b1;
            end

            NORM: begin
                if (!op_q) begin
                    if (acc_q[PW-1]) begin
                        mant_n = Nm'(acc_q >> (Nm + 1));
                        exp_n  = exp_q + 1'b1;
                    end else begin
                        mant_n = Nm'(acc_q >> Nm);
                        exp_n  = exp_q;
                    end
                end else begin
                    if (quo_q[Nm+1]) begin
                        mant_n = Nm'(quo_q >> 1);
                        exp_n  = exp_q;
                    end else begin
                        mant_n = Nm'(quo_q);
                        exp_n  = exp_q - 1'b1;
                    end
                end
                // exp_n is two's complement: MSB set means a negative exponent.
                if (!exp_n[EW-1] && (exp_n >= EW'(EMAX))) begin
                    pres_d   = {sign_q, {Ne{1'b1}}, {Nm{1'b0}}};
                    pflags_d = 4'b0010;
                end else if (exp_n[EW-1] || (exp_n == '0)) begin
                    pres_d   = {sign_q, {(W-1){1'b0}}};
                    pflags_d = 4'b0001;
                end else begin
                    pres_d   = {sign_q, exp_n[Ne-1:0], mant_n};
                    pflags_d = 4'b0000;
                end
                state_d = DONE;
            end

            DONE: begin
                res_d   = pres_q;
                flags_d = pflags_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // ready stays low through the done pulse and rises the cycle after.
        ready_d = (state_d == IDLE) && (state_q != DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            pres_q   <= '0;
            pflags_q <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            pres_q   <= pres_d;
            pflags_q <= pflags_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign res_o   = res_q;
    assign flags_o = flags_q;

endmodule

// File: tb/tb_float_muldiv_seq.sv
// Randomized and directed checks of float_muldiv_seq against an arithmetic model;
// a second instance covers the Nm=10, Ne=5 build.
module tb_float_muldiv_seq;
    localparam int NM   = 23;
    localparam int NE   = 8;
    localparam int W    = 1 + NE + NM;
    localparam int BIAS = 2 ** (NE - 1) - 1;
    localparam int EMAX = 2 ** NE - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, op = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          ready, done;
    logic [W-1:0]  res;
    logic [3:0]    flags;

    logic          start2 = 1'b0, op2 = 1'b0;
    logic [15:0]   a2 = '0, b2 = '0;
    logic          ready2, done2;
    logic [15:0]   res2;
    logic [3:0]    flags2;

    int checks = 0;
    int failures = 0;

    float_muldiv_seq #(.Nm(NM), .Ne(NE)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .op_a_i(a), .op_b_i(b), .ready_o(ready), .done_o(done),
        .res_o(res), .flags_o(flags)
    );

    float_muldiv_seq #(.Nm(10), .Ne(5)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .op_i(op2),
        .op_a_i(a2), .op_b_i(b2), .ready_o(ready2), .done_o(done2),
        .res_o(res2), .flags_o(flags2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns {flags, result}; special is set when the operands short-circuit.
    function automatic logic [W+3:0] model(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, output bit special);
        logic s;
        int ex, ey, e;
        longint mx, my, p, q, mant;
        logic [W-1:0] inf_v, nan_v, zero_v;
        s      = x[W-1] ^ y[W-1];
        ex     = int'(x[W-2:NM]);
        ey     = int'(y[W-2:NM]);
        mx     = (64'd1 << NM) | longint'(x[NM-1:0]);
        my     = (64'd1 << NM) | longint'(y[NM-1:0]);
        inf_v  = {s, {NE{1'b1}}, {NM{1'b0}}};
        nan_v  = {s, {NE{1'b1}}, {NM{1'b1}}};
        zero_v = {s, {(W-1){1'b0}}};
        special = 1'b1;
        if (!o) begin
            if ((ex == 0 && ey == EMAX) || (ex == EMAX && ey == 0)) return {4'b1000, nan_v};
            if (ex == EMAX || ey == EMAX) return {4'b0000, inf_v};
            if (ex == 0 || ey == 0) return {4'b0000, zero_v};
        end else begin
            if ((ex == 0 && ey == 0) || (ex == EMAX && ey == EMAX)) return {4'b1000, nan_v};
            if (ex == EMAX) return {4'b0000, inf_v};
            if (ey == 0) return {4'b0100, inf_v};
            if (ex == 0 || ey == EMAX) return {4'b0000, zero_v};
        end
        special = 1'b0;
        if (!o) begin
            p = mx * my;
            e = ex + ey - BIAS;
            if (p >= (64'd1 << (2 * NM + 1))) begin
                mant = p >> (NM + 1);
                e = e + 1;
            end else begin
                mant = p >> NM;
            end
        end else begin
            q = (mx << (NM + 1)) / my;
            e = ex - ey + BIAS;
            if (q < (64'd1 << (NM + 1))) begin
                q = q << 1;
                e = e - 1;
            end
            mant = q >> 1;
        end
        mant = mant & ((64'd1 << NM) - 1);
        if (e >= EMAX) return {4'b0010, inf_v};
        if (e <= 0) return {4'b0001, zero_v};
        return {4'b0000, s, e[NE-1:0], mant[NM-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        int c;
        int e;
        c = $urandom_range(0, 11);
        if (c == 0)      e = 0;
        else if (c == 1) e = EMAX;
        else if (c <= 3) e = $urandom_range(1, 20);
        else if (c <= 5) e = $urandom_range(EMAX - 20, EMAX - 1);
        else             e = $urandom_range(BIAS - 30, BIAS + 30);
        return {1'(($urandom & 1)), e[NE-1:0], NM'($urandom)};
    endfunction

    // Called at a negedge with ready high; returns at the negedge after done.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int poke_at);
        logic [W+3:0] e;
        bit sp;
        int lat;
        int rdy_hi;
        e = model(o, x, y, sp);
        rdy_hi = 0;
        check("ready_idle", 64'(ready), 64'd1);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (ready) rdy_hi++;
            if (lat == poke_at) begin
                start = 1'b1; op = ~o; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(sp ? 2 : (o ? NM + 5 : NM + 4)));
        check("busy_ready", 64'(rdy_hi), 64'd0);
        check("res", 64'(res), 64'(e[W-1:0]));
        check("flags", 64'(flags), 64'(e[W+3:W]));
        $display("op=%0d a=%h b=%h res=%h flags=%b lat=%0d", o, x, y, res, flags, lat);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("ready_back", 64'(ready), 64'd1);
    endtask

    task automatic directed(input string tag, input logic o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W+3:0] exp);
        run_op(o, x, y, -1);
        check(tag, {28'd0, flags, res}, 64'(exp));
    endtask

    initial begin
        int lat;
        int cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        directed("mul_3x2p5", 1'b0, 32'h40400000, 32'h40200000, {4'b0000, 32'h40F00000});
        directed("div_1_3",   1'b1, 32'h3F800000, 32'h40400000, {4'b0000, 32'h3EAAAAAA});
        directed("mul_sign",  1'b0, 32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000});
        directed("div_zero",  1'b1, 32'h3F800000, 32'h00000000, {4'b0100, 32'h7F800000});
        directed("zero_inf",  1'b0, 32'h00000000, 32'h7F800000, {4'b1000, 32'h7FFFFFFF});
        directed("ovf",       1'b0, 32'h7F000000, 32'h7F000000, {4'b0010, 32'h7F800000});
        directed("unf",       1'b0, 32'h00800000, 32'h00800000, {4'b0001, 32'h00000000});

        // Busy start 5 cycles in must be ignored, with a single done pulse.
        directed("busy_ignore", 1'b0, 32'h40400000, 32'h40200000, {4'b0000, 32'h40F00000});
        run_op(1'b0, 32'h40400000, 32'h40200000, 5);
        check("busy_res", 64'(res), 64'h40F00000);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("single_done", 64'(cnt), 64'd0);

        // Reset at cycle 10 of a divide.
        op = 1'b1; a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_res", 64'(res), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("mid_rst_nodone", 64'(cnt), 64'd0);
        directed("after_rst", 1'b1, 32'h3F800000, 32'h40400000, {4'b0000, 32'h3EAAAAAA});

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom & 1), rnd_operand(), rnd_operand(), -1);

        // Reduced-format instance: 3.0 * 2.5 with Nm=10, Ne=5.
        op2 = 1'b0; a2 = 16'h4200; b2 = 16'h4100; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("p2_latency", 64'(lat), 64'd14);
        check("p2_res", 64'(res2), 64'h4780);
        check("p2_flags", 64'(flags2), 64'd0);
        $display("op=0 a=4200 b=4100 res=%h flags=%b lat=%0d (Nm=10 Ne=5)", res2, flags2, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_muldiv_seq.md
# float_muldiv_seq

Parametrised, synthesizable multi-cycle floating-point multiplier/divider for the LM32 coprocessor. It replaces the behavioural `shortreal` multiply and divide in the float package with shift-add and restoring-division datapaths over a configurable `{s, exposant[Ne-1:0], mantisse[Nm-1:0]}` format. It also adds special-operand handling, status flags and a start/done handshake. It sits behind the coprocessor's operand registers, and one operation is in flight at a time.

## Interface
- `Nm`, default 23: mantissa width; the hidden 1 is implicit.
- `Ne`, default 8: exponent width; bias is `2**(Ne-1)-1`.
- `clk_i` input, 1 bit: the single clock.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `start_i` input, 1 bit: launches an operation; sampled only while `ready_o` is 1.
- `op_i` input, 1 bit: 0 = `op_a*op_b`, 1 = `op_a/op_b`; sampled with `start_i`.
- `op_a_i`, `op_b_i` input, `1+Ne+Nm` bits each: operands; sampled with `start_i`.
- `ready_o` output, 1 bit: high in IDLE.
- `done_o` output, 1 bit: one-cycle pulse when `res_o` and `flags_o` are updated.
- `res_o` output, `1+Ne+Nm` bits: result; held until the next `done_o`.
- `flags_o` output, 4 bits: `{inv, dz, ovf, unf}`; held with `res_o`.

## Operation
- **Encoding.**
  - exp = 0: zero; the mantissa is ignored, and there are no denormals.
  - exp = all-ones: infinity; the mantissa is ignored.
  - Otherwise the value is `(1.mant) * 2**(exp-bias)`.
  - Result sign is always `sa^sb`.
- **States:** IDLE, UNPACK, ITER, NORM, DONE.
  - IDLE → UNPACK on `start_i`.
  - UNPACK → DONE for special operands; otherwise UNPACK → ITER.
  - ITER runs N cycles, then → NORM; N = Nm+1 for mul, Nm+2 for div.
  - NORM → DONE → IDLE.
- **Special cases**, resolved in UNPACK:
  - 0·inf, 0/0, inf/inf: `{s, all-ones, all-ones}`, inv = 1.
  - finite nonzero / 0: inf, dz = 1.
  - inf·x, inf/x: inf.
  - 0·x, 0/x, x/inf: zero.
- **Mul.**
  - Shift-add of two Nm+1-bit significands gives a 2Nm+2-bit product.
  - If the product MSB is set, take bits [2Nm+1:Nm+1] and add 1 to the exponent; else take bits [2Nm:Nm].
  - Exponent `ea+eb-bias`, computed signed in Ne+2 bits.
- **Div.**
  - Restoring division of `ma<<(Nm+1)` by `mb` gives an Nm+2-bit quotient.
  - If the quotient MSB is clear, shift left 1 and subtract 1 from the exponent.
  - Exponent `ea-eb+bias`.
- **Rounding:** truncate toward zero; discarded bits are dropped, with no sticky bit.
- **Range:**
  - Final exp ≥ `2**Ne-1`: result is inf, ovf = 1.
  - Final exp ≤ 0: result is signed zero, unf = 1.
- **Busy:** `start_i` while not ready is ignored.

## Timing
- Let `start_i` be sampled at edge k.
  - Normal operation: `done_o` is high in the cycle after edge k+N+3, i.e. latency N+3. Mul = Nm+4 (27 at default), div = Nm+5 (28 at default).
  - Special operands: latency 2.
- `ready_o` returns high in the cycle after `done_o`. A back-to-back `start_i` is accepted in that cycle.
- **Reset values:**
  - State = IDLE, so `ready_o` = 1.
  - `done_o` = 0, `res_o` = 0, `flags_o` = 0.
- **Reset mid-operation:** the operation is aborted, no `done_o` is issued, and the outputs take their reset values.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Defaults Nm = 23, Ne = 8; values are hex.
- **Mul 3.0·2.5:** `3F...`: `40400000 · 40200000` → `40F00000`, flags 0, `done_o` 27 cycles after start; `ready_o` low in between.
- **Div 1/3 with truncation:** `3F800000 / 40400000` → `3EAAAAAA`, flags 0, latency 28. Sign check: `C0000000 · 40400000` → `C0C00000`.
- **Specials:**
  - `3F800000 / 00000000` → `7F800000`, flags `0100`, latency 2.
  - `00000000 · 7F800000` → `7FFFFFFF`, flags `1000`.
- **Range:**
  - `7F000000 · 7F000000` → `7F800000`, flags `0010`.
  - `00800000 · 00800000` → `00000000`, flags `0001`.
- **Handshake:**
  - Pulse `start_i` 5 cycles after a start: it is ignored, the first result is unchanged, and exactly one `done_o` occurs.
  - Start in the cycle after `done_o`: accepted.
- **Reset mid-operation:** assert `rst_i` at cycle 10 of a div → no `done_o`, `res_o` = 0, `ready_o` = 1. A new op after release completes correctly.
- **Reparameterisation:** rebuild with Nm = 10, Ne = 5; 3.0·2.5 → `{0, 10001, 1110000000}`, latency 14.
